// File: rtl/trace_match_recorder_if.sv
// Trace stream and match-record read port bundle for trace_match_recorder.
// master = host/stimulus side, slave = recorder side.
interface trace_match_recorder_if #(
  parameter int pTS_WIDTH = 56
);
  logic [7:0]           trace_data;
  logic                 trace_valid;
  logic                 fifo_rd;
  logic [pTS_WIDTH+7:0] fifo_dout;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 fifo_overflow;
  logic                 ovf_clr;

  modport master (
    output trace_data, trace_valid, fifo_rd, ovf_clr,
    input  fifo_dout, fifo_empty, fifo_full, fifo_overflow
  );

  modport slave (
    input  trace_data, trace_valid, fifo_rd, ovf_clr,
    output fifo_dout, fifo_empty, fifo_full, fifo_overflow
  );
endinterface

// File: rtl/trace_match_recorder.sv
// Multi-rule masked trace pattern matcher with trigger output and a
// first-word fall-through FIFO of timestamped {rule, timestamp} records.
module trace_match_recorder #(
  parameter int pRULES      = 8,
  parameter int pWIN_BYTES  = 8,
  parameter int pTS_WIDTH   = 56,
  parameter int pFIFO_DEPTH = 16
) (
  input  logic                    trace_clk,
  input  logic                    resetn,
  input  logic                    cfg_wr,
  input  logic                    cfg_sel,
  input  logic [7:0]              cfg_rule,
  input  logic [8*pWIN_BYTES-1:0] cfg_data,
  input  logic [pRULES-1:0]       rule_enable,
  input  logic                    arm,
  input  logic                    trig_toggle,
  output logic                    trig_out,
  trace_match_recorder_if.slave   bus
);

  localparam int W  = 8 * pWIN_BYTES;
  localparam int RW = 8 + pTS_WIDTH;
  localparam int AW = $clog2(pFIFO_DEPTH);

  localparam logic [pTS_WIDTH-1:0] TS_ONE   = 1;
  localparam logic [AW-1:0]        PTR_ONE  = 1;
  localparam logic [AW:0]          CNT_ONE  = 1;
  localparam logic [AW:0]          CNT_FULL = (AW+1)'(pFIFO_DEPTH);

  logic [W-1:0]         pat  [pRULES];
  logic [W-1:0]         mask [pRULES];
  logic [W-1:0]         win;
  logic                 shift_q;
  logic [pTS_WIDTH-1:0] ts;
  logic [pTS_WIDTH-1:0] ts_lat;

  logic                 hit_any;
  logic [7:0]           hit_rule;
  logic                 ev;
  logic                 pulse_q;

  logic [RW-1:0]        mem [pFIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          cnt;
  logic [AW:0]          cnt_n;
  logic                 empty_q;
  logic                 full_q;
  logic                 ovf_q;
  logic                 rd_ok;
  logic                 wr_ok;

  always_ff @(posedge trace_clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < pRULES; r++) begin
        pat[r]  <= '0;
        mask[r] <= '0;
      end
    end else if (cfg_wr) begin
      for (int r = 0; r < pRULES; r++) begin
        if (cfg_rule == 8'(r)) begin
          if (cfg_sel) mask[r] <= cfg_data;
          else         pat[r]  <= cfg_data;
        end
      end
    end
  end

  // ts_lat holds the count seen by the edge that took the newest byte
  always_ff @(posedge trace_clk or negedge resetn) begin
    if (!resetn) begin
      win     <= '0;
      shift_q <= 1'b0;
      ts      <= '0;
      ts_lat  <= '0;
    end else begin
      ts      <= ts + TS_ONE;
      shift_q <= bus.trace_valid;
      if (bus.trace_valid) begin
        win    <= W'({win, bus.trace_data});
        ts_lat <= ts;
      end
    end
  end

  // descending scan so the lowest-index hit is the one kept
  always_comb begin
    hit_any  = 1'b0;
    hit_rule = '0;
    for (int r = pRULES - 1; r >= 0; r--) begin
      if (rule_enable[r] &&
          ((win & mask[r]) == (pat[r] & mask[r]))) begin
        hit_any  = 1'b1;
        hit_rule = 8'(r);
      end
    end
  end

  assign ev = shift_q & arm & hit_any;

  // pulse_q marks a pulse-mode high so a mode switch never drops a toggle level
  always_ff @(posedge trace_clk or negedge resetn) begin
    if (!resetn) begin
      trig_out <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      pulse_q <= ev & ~trig_toggle;
      if (ev)           trig_out <= trig_toggle ? ~trig_out : 1'b1;
      else if (pulse_q) trig_out <= 1'b0;
    end
  end

  assign rd_ok = bus.fifo_rd & ~empty_q;
  assign wr_ok = ev & (~full_q | rd_ok);

  always_comb begin
    cnt_n = cnt;
    if (wr_ok & ~rd_ok)      cnt_n = cnt + CNT_ONE;
    else if (rd_ok & ~wr_ok) cnt_n = cnt - CNT_ONE;
  end

  always_ff @(posedge trace_clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      empty_q <= (cnt_n == '0);
      full_q  <= (cnt_n == CNT_FULL);
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      if (ev & full_q & ~rd_ok) ovf_q <= 1'b1;
      else if (bus.ovf_clr)     ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge trace_clk) begin
    if (wr_ok) mem[wr_ptr] <= {hit_rule, ts_lat};
  end

  assign bus.fifo_dout     = empty_q ? '0 : mem[rd_ptr];
  assign bus.fifo_empty    = empty_q;
  assign bus.fifo_full     = full_q;
  assign bus.fifo_overflow = ovf_q;

endmodule

// File: tb/tb_trace_match_recorder.sv
// Directed self-checking bench for trace_match_recorder.
// Expected records are built from a bench-side cycle counter.
module tb_trace_match_recorder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cfg_wr;
  logic        cfg_sel;
  logic [7:0]  cfg_rule;
  logic [63:0] cfg_data;
  logic [7:0]  rule_enable;
  logic        arm;
  logic        trig_toggle;
  logic        trig_out;

  trace_match_recorder_if #(.pTS_WIDTH(56)) bus ();

  trace_match_recorder #(
    .pRULES(8), .pWIN_BYTES(8), .pTS_WIDTH(56), .pFIFO_DEPTH(16)
  ) dut (
    .trace_clk   (clk),
    .resetn      (resetn),
    .cfg_wr      (cfg_wr),
    .cfg_sel     (cfg_sel),
    .cfg_rule    (cfg_rule),
    .cfg_data    (cfg_data),
    .rule_enable (rule_enable),
    .arm         (arm),
    .trig_toggle (trig_toggle),
    .trig_out    (trig_out),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  logic [55:0] tb_ts;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) tb_ts <= '0;
    else         tb_ts <= tb_ts + 56'd1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg(input logic sel, input logic [7:0] rule,
                     input logic [63:0] d);
    cfg_wr = 1'b1; cfg_sel = sel; cfg_rule = rule; cfg_data = d;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic pop();
    bus.fifo_rd = 1'b1;
    tick();
    bus.fifo_rd = 1'b0;
  endtask

  function automatic logic [63:0] rec(input logic [7:0] r,
                                      input logic [55:0] t);
    return {r, t};
  endfunction

  logic [55:0] exp_ts;
  logic [55:0] tsv [3];
  logic [55:0] tsq [20];

  initial begin
    resetn = 1'b0; cfg_wr = 1'b0; cfg_sel = 1'b0; cfg_rule = '0;
    cfg_data = '0; rule_enable = '0; arm = 1'b0; trig_toggle = 1'b0;
    bus.trace_data = '0; bus.trace_valid = 1'b0;
    bus.fifo_rd = 1'b0; bus.ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_trig",  trig_out,          1'b0);
    chk("rst_empty", bus.fifo_empty,    1'b1);
    chk("rst_full",  bus.fifo_full,     1'b0);
    chk("rst_ovf",   bus.fifo_overflow, 1'b0);
    chk("rst_dout",  bus.fifo_dout,     64'h0);
    resetn = 1'b1;
    tick();

    // single rule DEADBEEF
    cfg(1'b0, 8'd3, 64'hDEAD_BEEF);
    cfg(1'b1, 8'd3, 64'hFFFF_FFFF);
    rule_enable = 8'h08; arm = 1'b1;
    bus.trace_valid = 1'b1;
    bus.trace_data = 8'hDE; tick();
    bus.trace_data = 8'hAD; tick();
    bus.trace_data = 8'hBE; tick();
    exp_ts = tb_ts;
    bus.trace_data = 8'hEF; tick();
    bus.trace_valid = 1'b0;
    chk("t1_trig_pre",  trig_out,       1'b0);
    chk("t1_empty_pre", bus.fifo_empty, 1'b1);
    tick();
    chk("t1_trig",  trig_out,       1'b1);
    chk("t1_empty", bus.fifo_empty, 1'b0);
    chk("t1_rec",   bus.fifo_dout,  rec(8'd3, exp_ts));
    tick();
    chk("t1_trig_end", trig_out, 1'b0);
    repeat (3) tick();
    pop();
    chk("t1_no_repeat", bus.fifo_empty, 1'b1);

    // rules 1 and 5 identical
    cfg(1'b0, 8'd1, 64'h1234); cfg(1'b1, 8'd1, 64'hFFFF);
    cfg(1'b0, 8'd5, 64'h1234); cfg(1'b1, 8'd5, 64'hFFFF);
    rule_enable = 8'h22;
    bus.trace_valid = 1'b1;
    bus.trace_data = 8'h12; tick();
    exp_ts = tb_ts;
    bus.trace_data = 8'h34; tick();
    bus.trace_valid = 1'b0;
    tick();
    chk("t2_trig", trig_out,      1'b1);
    chk("t2_rec",  bus.fifo_dout, rec(8'd1, exp_ts));
    tick();
    chk("t2_trig_end", trig_out, 1'b0);
    pop();
    chk("t2_single", bus.fifo_empty, 1'b1);

    // toggle mode, three matches
    trig_toggle = 1'b1; rule_enable = 8'h02;
    for (int m = 0; m < 3; m++) begin
      bus.trace_valid = 1'b1;
      bus.trace_data = 8'h12; tick();
      tsv[m] = tb_ts;
      bus.trace_data = 8'h34; tick();
      bus.trace_valid = 1'b0;
      tick();
      chk($sformatf("t3_trig%0d", m), trig_out, (m % 2 == 0) ? 1'b1 : 1'b0);
    end
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("t3_rec%0d", m), bus.fifo_dout, rec(8'd1, tsv[m]));
      pop();
    end
    chk("t3_empty", bus.fifo_empty, 1'b1);

    // back to pulse mode: level held until next event
    trig_toggle = 1'b0;
    tick();
    chk("t4_hold", trig_out, 1'b1);
    bus.trace_valid = 1'b1;
    bus.trace_data = 8'h12; tick();
    bus.trace_data = 8'h34; tick();
    bus.trace_valid = 1'b0;
    tick();
    chk("t4_pulse", trig_out, 1'b1);
    tick();
    chk("t4_low", trig_out, 1'b0);
    pop();

    // all-zero mask on rule 0, overflow
    rule_enable = 8'h01;
    bus.trace_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.trace_data = 8'(i);
      tsq[i] = tb_ts;
      tick();
      if (i == 10) chk("t5_trig_run", trig_out, 1'b1);
      if (i == 15) chk("t5_full15", bus.fifo_full, 1'b0);
      if (i == 16) begin
        chk("t5_full16", bus.fifo_full,     1'b1);
        chk("t5_ovf16",  bus.fifo_overflow, 1'b0);
      end
      if (i == 17) chk("t5_ovf17", bus.fifo_overflow, 1'b1);
    end
    bus.trace_valid = 1'b0;
    tick();
    chk("t5_full", bus.fifo_full,     1'b1);
    chk("t5_ovf",  bus.fifo_overflow, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t5_rec%0d", i), bus.fifo_dout, rec(8'd0, tsq[i]));
      pop();
    end
    chk("t5_empty",     bus.fifo_empty,    1'b1);
    chk("t5_ovf_stick", bus.fifo_overflow, 1'b1);
    bus.ovf_clr = 1'b1; tick(); bus.ovf_clr = 1'b0;
    chk("t5_ovf_clr", bus.fifo_overflow, 1'b0);

    // disarmed / disabled
    arm = 1'b0;
    bus.trace_valid = 1'b1; bus.trace_data = 8'h55; tick();
    bus.trace_valid = 1'b0; tick(); tick();
    chk("t6_arm_empty", bus.fifo_empty, 1'b1);
    chk("t6_arm_trig",  trig_out,       1'b0);
    arm = 1'b1; rule_enable = 8'h00;
    bus.trace_valid = 1'b1; bus.trace_data = 8'h66; tick();
    bus.trace_valid = 1'b0; tick(); tick();
    chk("t6_en_empty", bus.fifo_empty, 1'b1);
    chk("t6_en_trig",  trig_out,       1'b0);

    // reset with records queued
    rule_enable = 8'h01;
    bus.trace_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.trace_data = 8'(8'h40 + i);
      tick();
    end
    bus.trace_valid = 1'b0;
    tick();
    chk("t7_queued", bus.fifo_empty, 1'b0);
    chk("t7_trig",   trig_out,       1'b1);
    resetn = 1'b0;
    #1;
    chk("t7_rst_empty", bus.fifo_empty, 1'b1);
    chk("t7_rst_trig",  trig_out,       1'b0);
    chk("t7_rst_dout",  bus.fifo_dout,  64'h0);
    rule_enable = 8'h00;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    bus.trace_valid = 1'b1; bus.trace_data = 8'h77; tick();
    bus.trace_valid = 1'b0; tick(); tick();
    chk("t7_no_match", bus.fifo_empty, 1'b1);
    rule_enable = 8'h08;
    bus.trace_valid = 1'b1; bus.trace_data = 8'h11; tick();
    bus.trace_valid = 1'b0; tick();
    chk("t7_mask0_hit",  bus.fifo_empty,       1'b0);
    chk("t7_mask0_rule", bus.fifo_dout[63:56], 8'd3);
    pop();
    cfg(1'b0, 8'd3, 64'hDEAD_BEEF);
    cfg(1'b1, 8'd3, 64'hFFFF_FFFF);
    bus.trace_valid = 1'b1; bus.trace_data = 8'h22; tick();
    bus.trace_valid = 1'b0; tick(); tick();
    chk("t7_rewritten", bus.fifo_empty, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
